// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_unit : PC + req/ack instruction fetch, valid/ready to decode.
// Optional macro MISALIGN_TRAP_EN adds a sticky misaligned-redirect fault.
// Revision: 1.0
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  output logic [31:0]       instr_o,
  output logic [15:0]       imm16_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_offset_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_target_i,
  output logic              misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
`ifdef MISALIGN_TRAP_EN
    ,S_FAULT = 2'd3
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_pc_raw;

  assign pc_plus4 = pc_q + ADDR_W'(4);

  // Redirect priority: jump over taken branch over sequential.
  always_comb begin
    next_pc_raw = pc_plus4;
    if (jump_i) begin
      next_pc_raw = {pc_plus4[ADDR_W-1:ADDR_W-4], jump_target_i, 2'b00};
    end else if (branch_taken_i) begin
      next_pc_raw = pc_plus4 + (branch_offset_i << 2);
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`else
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack_i) begin
          instr_d = imem_data_i;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (instr_ready_i) begin
`ifdef MISALIGN_TRAP_EN
          pc_d = next_pc_raw;
          if (next_pc_raw[1:0] != 2'b00) begin
            state_d    = S_FAULT;
            misalign_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
`else
          pc_d    = next_pc_raw & ALIGN_MASK;
          state_d = S_REQ;
`endif
        end
      end
`ifdef MISALIGN_TRAP_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign imem_req_o    = (state_q == S_REQ);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == S_VALID);
  assign instr_o       = instr_q;
  assign imm16_o       = instr_q[15:0];
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
`ifdef MISALIGN_TRAP_EN
  assign misalign_o    = misalign_q;
`else
  assign misalign_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// tb_instr_fetch_unit : scoreboard bench for the fetch unit (default build).
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic [31:0] instr_o;
  logic [15:0] imm16_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_offset_i = '0;
  logic        jump_i = 1'b0;
  logic [25:0] jump_target_i = '0;
  logic        misalign_o;

  int checks = 0;
  int passes = 0;
  logic [63:0] sb[$];   // {pc, instr} expected at each instr_valid_o

  instr_fetch_unit #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .instr_o(instr_o), .imm16_o(imm16_o),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .branch_taken_i(branch_taken_i), .branch_offset_i(branch_offset_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Waits (bounded) for a request, acks it with data, records expectation.
  task automatic fetch_word(input logic [31:0] data, output bit timeout);
    int n;
    n = 0;
    timeout = 1'b0;
    while (!imem_req_o && n < 8) begin
      tick();
      n++;
    end
    if (!imem_req_o) begin
      timeout = 1'b1;
    end else begin
      imem_ack_i  = 1'b1;
      imem_data_i = data;
      sb.push_back({imem_addr_o, data});
      tick();
      imem_ack_i  = 1'b0;
      imem_data_i = '0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    tick(); tick();
    checks++; if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); else passes++;
    checks++; if (imem_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req_o); else passes++;
    checks++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid_o); else passes++;
    checks++; if (instr_o !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr_o); else passes++;
    checks++; if (misalign_o !== 1'b0) $display("FAIL reset_misalign: got %b want 0", misalign_o); else passes++;
    rst_i = 1'b1;
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0)
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); else passes++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    logic [31:0] d;
    logic [63:0] e;
    int retired;
    exp_addr = 32'h0;
    retired = 0;
    instr_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      imem_ack_i = 1'b0;
      if (imem_req_o) begin
        checks++; if (imem_addr_o !== exp_addr)
          $display("FAIL seq_addr: got %h want %h", imem_addr_o, exp_addr); else passes++;
        d = {16'hC0DE, 16'h1000 + exp_addr[15:0]};
        imem_ack_i  = 1'b1;
        imem_data_i = d;
        sb.push_back({imem_addr_o, d});
      end
      if (instr_valid_o) begin
        if (sb.size() == 0) begin
          checks++; $display("FAIL seq_sb_empty: got valid with no expected entry");
        end else begin
          e = sb.pop_front();
          checks++; if ({pc_o, instr_o} !== e)
            $display("FAIL seq_word: got pc=%h instr=%h want pc=%h instr=%h", pc_o, instr_o, e[63:32], e[31:0]); else passes++;
          checks++; if (imm16_o !== e[15:0])
            $display("FAIL seq_imm16: got %h want %h", imm16_o, e[15:0]); else passes++;
          checks++; if (pc_plus4_o !== e[63:32] + 32'd4)
            $display("FAIL seq_pc_plus4: got %h want %h", pc_plus4_o, e[63:32] + 32'd4); else passes++;
        end
        exp_addr = exp_addr + 32'd4;
        retired++;
      end
      checks++; if ((imem_req_o ^ instr_valid_o) !== 1'b1)
        $display("FAIL seq_alternate: got req=%b valid=%b want exactly one high", imem_req_o, instr_valid_o); else passes++;
      tick();
    end
    imem_ack_i = 1'b0;
    checks++; if (retired != 4) $display("FAIL seq_retired: got %0d want 4", retired); else passes++;
  endtask

  task automatic test_delayed_ack();
    logic [63:0] e;
    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || instr_valid_o !== 1'b0)
        $display("FAIL delay_hold: cycle %0d got req=%b addr=%h valid=%b want req=1 addr=00000010 valid=0",
                 i, imem_req_o, imem_addr_o, instr_valid_o); else passes++;
      if (i == 2) begin
        imem_ack_i  = 1'b1;
        imem_data_i = 32'h2008FFFC;
        sb.push_back({32'h10, 32'h2008FFFC});
      end
      tick();
    end
    imem_ack_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b1) $display("FAIL delay_valid: got %b want 1", instr_valid_o); else passes++;
    e = sb.pop_front();
    checks++; if ({pc_o, instr_o} !== e)
      $display("FAIL delay_word: got pc=%h instr=%h want pc=%h instr=%h", pc_o, instr_o, e[63:32], e[31:0]); else passes++;
    checks++; if (imm16_o !== 16'hFFFC) $display("FAIL delay_imm16: got %h want fffc", imm16_o); else passes++;
  endtask

  task automatic test_backpressure();
    instr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0)
        $display("FAIL bp_handshake: cycle %0d got valid=%b req=%b want valid=1 req=0", i, instr_valid_o, imem_req_o); else passes++;
      checks++; if (instr_o !== 32'h2008FFFC || pc_o !== 32'h10)
        $display("FAIL bp_hold: cycle %0d got instr=%h pc=%h want instr=2008fffc pc=00000010", i, instr_o, pc_o); else passes++;
      imem_ack_i  = (i == 1);
      imem_data_i = 32'hDEADBEEF;
      branch_taken_i  = 1'b1;
      branch_offset_i = 32'h40;
      tick();
    end
    imem_ack_i = 1'b0;
    imem_data_i = '0;
    branch_taken_i = 1'b0;
    instr_ready_i = 1'b1;
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h14)
      $display("FAIL bp_release: got req=%b addr=%h want req=1 addr=00000014", imem_req_o, imem_addr_o); else passes++;
  endtask

  task automatic test_redirect();
    bit to;
    logic [63:0] e;
    fetch_word(32'h0800_0040, to);
    checks++; if (to !== 1'b0) $display("FAIL redir_timeout1: got timeout=%b want 0", to); else passes++;
    e = sb.pop_front();
    checks++; if ({pc_o, instr_o} !== e)
      $display("FAIL redir_word1: got pc=%h instr=%h want pc=%h instr=%h", pc_o, instr_o, e[63:32], e[31:0]); else passes++;
    jump_i = 1'b1; jump_target_i = 26'h40;
    tick();
    jump_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h100) $display("FAIL jump_addr: got %h want 00000100", imem_addr_o); else passes++;

    fetch_word(32'h1000_FFFE, to);
    e = sb.pop_front();
    checks++; if ({pc_o, instr_o} !== e)
      $display("FAIL redir_word2: got pc=%h instr=%h want pc=%h instr=%h", pc_o, instr_o, e[63:32], e[31:0]); else passes++;
    branch_taken_i = 1'b1; branch_offset_i = 32'hFFFF_FFFE;
    tick();
    branch_taken_i = 1'b0;
    checks++; if (imem_addr_o !== 32'hFC) $display("FAIL branch_back_addr: got %h want 000000fc", imem_addr_o); else passes++;

    fetch_word(32'h0800_0040, to);
    e = sb.pop_front();
    checks++; if ({pc_o, instr_o} !== e)
      $display("FAIL redir_word3: got pc=%h instr=%h want pc=%h instr=%h", pc_o, instr_o, e[63:32], e[31:0]); else passes++;
    branch_taken_i = 1'b1; branch_offset_i = 32'hFFFF_FFFE;
    jump_i = 1'b1; jump_target_i = 26'h40;
    tick();
    branch_taken_i = 1'b0; jump_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h100) $display("FAIL jump_priority_addr: got %h want 00000100", imem_addr_o); else passes++;
  endtask

  task automatic test_wrap();
    bit to;
    logic [63:0] e;
    fetch_word(32'h1000_FFBE, to);
    e = sb.pop_front();
    checks++; if ({pc_o, instr_o} !== e)
      $display("FAIL wrap_word1: got pc=%h instr=%h want pc=%h instr=%h", pc_o, instr_o, e[63:32], e[31:0]); else passes++;
    branch_taken_i = 1'b1; branch_offset_i = 32'hFFFF_FFBE;
    tick();
    branch_taken_i = 1'b0;
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_branch_addr: got %h want fffffffc", imem_addr_o); else passes++;
    fetch_word(32'h0000_1234, to);
    e = sb.pop_front();
    checks++; if ({pc_o, instr_o} !== e)
      $display("FAIL wrap_word2: got pc=%h instr=%h want pc=%h instr=%h", pc_o, instr_o, e[63:32], e[31:0]); else passes++;
    checks++; if (pc_plus4_o !== 32'h0) $display("FAIL wrap_pc_plus4: got %h want 00000000", pc_plus4_o); else passes++;
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0)
      $display("FAIL wrap_seq_addr: got req=%b addr=%h want req=1 addr=00000000", imem_req_o, imem_addr_o); else passes++;
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [63:0] e;
    fetch_word(32'h0000_5555, to);
    e = sb.pop_front();
    checks++; if ({pc_o, instr_o} !== e)
      $display("FAIL mid_word1: got pc=%h instr=%h want pc=%h instr=%h", pc_o, instr_o, e[63:32], e[31:0]); else passes++;
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4)
      $display("FAIL mid_pre_req: got req=%b addr=%h want req=1 addr=00000004", imem_req_o, imem_addr_o); else passes++;
    rst_i = 1'b0;
    tick();
    checks++; if (pc_o !== 32'h0 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0)
      $display("FAIL mid_reset: got pc=%h req=%b valid=%b want pc=0 req=0 valid=0", pc_o, imem_req_o, instr_valid_o); else passes++;
    rst_i = 1'b1;
    imem_ack_i = 1'b1;
    imem_data_i = 32'hBAD0_BAD0;
    tick();
    imem_ack_i = 1'b0;
    imem_data_i = '0;
    checks++; if (imem_req_o !== 1'b1 || instr_valid_o !== 1'b0 || instr_o !== 32'h0 || imem_addr_o !== 32'h0)
      $display("FAIL late_ack: got req=%b valid=%b instr=%h addr=%h want req=1 valid=0 instr=0 addr=0",
               imem_req_o, instr_valid_o, instr_o, imem_addr_o); else passes++;
    fetch_word(32'h1111_2222, to);
    checks++; if (to !== 1'b0) $display("FAIL mid_timeout: got timeout=%b want 0", to); else passes++;
    e = sb.pop_front();
    checks++; if ({pc_o, instr_o} !== e || imm16_o !== 16'h2222)
      $display("FAIL mid_refetch: got pc=%h instr=%h imm=%h want pc=%h instr=%h imm=2222",
               pc_o, instr_o, imm16_o, e[63:32], e[31:0]); else passes++;
    checks++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d entries want 0", sb.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_delayed_ack();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the sign-extension stage.
- Holds the PC and issues requests to a variable-latency instruction memory over a req/ack handshake.
- Registers the returned instruction and presents its low 16 bits (imm16_o) to the sign extender, with a valid/ready handshake toward decode.
- Computes the next PC from PC+4, branch offset (the sign-extended immediate fed back) or jump target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and memory address width; fixed at 32 in this revision.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous active-low reset.
- imem_req_o  out  1  fetch request to instruction memory.
- imem_addr_o  out  32  fetch address (= pc_o).
- imem_ack_i  in  1  memory ack; imem_data_i valid this cycle.
- imem_data_i  in  32  fetched instruction word.
- instr_o  out  32  registered instruction.
- imm16_o  out  16  instr_o[15:0], to sign extender.
- instr_valid_o  out  1  instr_o/pc_o valid for decode.
- instr_ready_i  in  1  decode accepts current instruction.
- pc_o  out  32  PC of instr_o / current fetch.
- pc_plus4_o  out  32  pc_o + 4, wraps mod 2^32.
- branch_taken_i  in  1  branch resolved taken for current instr.
- branch_offset_i  in  32  sign-extended word offset.
- jump_i  in  1  current instr is a jump.
- jump_target_i  in  26  instr jump field.
- misalign_o  out  1  misaligned redirect flag (only with MISALIGN_TRAP_EN; tied 0 otherwise).

Behaviour:
- Reset: when rst_i=0 at a rising edge:
  - pc_o=RESET_PC, instr_o=0, state=S_IDLE, misalign_o=0.
  - Outputs imem_req_o=0, instr_valid_o=0.
  - Reset mid-transaction abandons the request; a late imem_ack_i is ignored.
- States:
  - S_IDLE: req=0, valid=0. Next cycle goes to S_REQ unconditionally.
  - S_REQ: imem_req_o=1, imem_addr_o=pc_o, valid=0. On imem_ack_i=1: instr_o<=imem_data_i, go S_VALID. Otherwise stay; address held stable.
  - S_VALID: instr_valid_o=1, req=0. On instr_ready_i=1 (retire handshake): pc_o<=next_pc, go S_REQ. Otherwise hold instr_o and pc_o unchanged.
  - S_FAULT: exists only with MISALIGN_TRAP_EN. req=0, valid=0, misalign_o=1; left only by reset.
- Latency:
  - Minimum 1 cycle from req to ack: imem_ack_i in the first S_REQ cycle gives instr_valid_o on the next cycle.
  - With zero-wait memory and ready held high, one instruction retires every 2 cycles.
- next_pc, evaluated only in the S_VALID && instr_ready_i cycle:
  - Priority: jump_i > branch_taken_i > sequential.
  - Jump: {pc_plus4_o[31:28], jump_target_i, 2'b00}.
  - Branch: pc_plus4_o + (branch_offset_i << 2), 32-bit wrap, carry discarded.
  - Sequential: pc_plus4_o; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Control inputs sampled only in that cycle:
  - branch/jump inputs are ignored in every other cycle.
  - imem_ack_i is ignored outside S_REQ.
- imm16_o is a pure slice of the instr_o register: no extra latency, and it is stable while valid.
- imem_data_i is captured only on an ack in S_REQ.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - If the selected next_pc has bits[1:0] != 0 at retire, go to S_FAULT instead of S_REQ.
  - pc_o loads the offending value; misalign_o=1 until reset.
- Not defined:
  - next_pc[1:0] forced to 2'b00; misalign_o tied 0; no S_FAULT state.
  - Jump targets are always aligned, so only branch arithmetic can ever misalign.

Test Plan:
- Reset then zero-wait memory, ready=1, no redirects:
  - imem_addr_o sequence 0x0, 0x4, 0x8, with instr_valid_o on every second cycle.
  - imm16_o = imem_data_i[15:0] of each word.
- Ack delayed 3 cycles:
  - imem_req_o high for 3 cycles with addr 0x10 held stable.
  - Ack with 0x2008FFFC gives instr_o=0x2008FFFC and imm16_o=0xFFFC next cycle.
- Backpressure: instr_ready_i=0 for 4 cycles in S_VALID.
  - instr_o and pc_o unchanged, no new request.
  - A stray imem_ack_i in this window is ignored.
- pc_o=0x100, branch_taken_i=1, branch_offset_i=0xFFFFFFFE, retire:
  - next fetch addr 0x104 - 8 = 0xFC.
  - Also assert jump_i=1 with jump_target_i=0x0000040: jump wins, addr 0x100.
- pc_o=0xFFFFFFFC, sequential retire -> next fetch addr 0x00000000.
- rst_i=0 asserted during S_REQ with a later ack:
  - pc_o=RESET_PC, imem_req_o=0 for one cycle, and the late ack is discarded.
  - With MISALIGN_TRAP_EN, a branch whose computed next_pc has bits[1:0] != 0 enters S_FAULT, with misalign_o=1 and no further requests.
  - Because the shifted offset keeps next_pc aligned whenever pc_o is aligned, this needs a bench forcing of pc_o (e.g. pc_o=0x102, branch_offset_i=0 -> next_pc 0x106).
